// File: rtl/usb_fs_packet_tx_if.sv
// Request/status/line bundle between a packet initiator and usb_fs_packet_tx.
interface usb_fs_packet_tx_if;
  logic       start;
  logic [3:0] pid;
  logic [6:0] addr;
  logic [3:0] endp;
  logic       busy;
  logic       done;
  logic       err;
  logic       tx_en;
  logic       tx_j;
  logic       tx_se0;

  modport master (
    output start, pid, addr, endp,
    input  busy, done, err, tx_en, tx_j, tx_se0
  );

  modport slave (
    input  start, pid, addr, endp,
    output busy, done, err, tx_en, tx_j, tx_se0
  );
endinterface

// File: rtl/usb_fs_packet_tx.sv
// Full-speed USB token/handshake packet transmitter: SYNC, PID, CRC5, bit
// stuffing, NRZI and EOP onto J/K/SE0 line drive signals.
module usb_fs_packet_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned STUFF_RUN    = 6
) (
  input logic               clk_48,
  input logic               rst,
  usb_fs_packet_tx_if.slave bus
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned OW = $clog2(STUFF_RUN + 1);
  localparam logic [TW-1:0] TimerLast = TW'(CLKS_PER_BIT - 1);
  localparam logic [OW-1:0] StuffRun  = OW'(STUFF_RUN);

  typedef enum logic [2:0] {StIdle, StSync, StPid, StField, StCrc, StEop} state_e;

  // CRC5 (x^5+x^2+1, init all ones) over the 11-bit field, LSB first, inverted.
  function automatic logic [4:0] crc5(input logic [10:0] field);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      if (c[4] ^ field[i]) c = {c[3:0], 1'b0} ^ 5'h05;
      else                 c = {c[3:0], 1'b0};
    end
    return ~c;
  endfunction

  // Packet section that a given serial bit index belongs to.
  function automatic state_e bit_state(input logic [5:0] idx);
    state_e s;
    if (idx < 6'd8)       s = StSync;
    else if (idx < 6'd16) s = StPid;
    else if (idx < 6'd27) s = StField;
    else                  s = StCrc;
    return s;
  endfunction

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   sr_q, sr_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [5:0]    nbits_q, nbits_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [1:0]    eop_cnt_q, eop_cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          tx_en_q, tx_en_d;
  logic          tx_j_q, tx_j_d;
  logic          tx_se0_q, tx_se0_d;

  logic          bit_end;
  logic          pid_ok;
  logic          token;
  logic [4:0]    crc;
  logic [31:0]   load;

  // Whole packet image in transmit order; CRC bits reversed so crc[4] goes first.
  always_comb begin
    token  = (bus.pid[1:0] == 2'b01);
    pid_ok = token || (bus.pid[1:0] == 2'b10);
    crc    = crc5({bus.endp, bus.addr});
    load   = {crc[0], crc[1], crc[2], crc[3], crc[4], bus.endp, bus.addr,
              ~bus.pid, bus.pid, 8'h80};
  end

  // Next-state: bit timer, serialiser, stuffing, NRZI and EOP sequencing.
  always_comb begin
    bit_end   = (timer_q == TimerLast);
    state_d   = state_q;
    timer_d   = timer_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    nbits_d   = nbits_q;
    ones_d    = ones_q;
    eop_cnt_d = eop_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tx_en_d   = tx_en_q;
    tx_j_d    = tx_j_q;
    tx_se0_d  = tx_se0_q;

    if (state_q != StIdle) timer_d = bit_end ? '0 : timer_q + TW'(1);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (pid_ok) begin
            // First SYNC bit goes on the line straight away.
            tx_j_d    = load[0] ? tx_j_q : ~tx_j_q;
            ones_d    = load[0] ? OW'(1) : '0;
            sr_d      = load >> 1;
            bit_cnt_d = 6'd1;
            nbits_d   = token ? 6'd32 : 6'd16;
            timer_d   = '0;
            busy_d    = 1'b1;
            tx_en_d   = 1'b1;
            tx_se0_d  = 1'b0;
            state_d   = StSync;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSync, StPid, StField, StCrc: begin
        if (bit_end) begin
          if (ones_q == StuffRun) begin
            // Stuffed zero: forced transition, no packet bit consumed.
            tx_j_d = ~tx_j_q;
            ones_d = '0;
          end else if (bit_cnt_q != nbits_q) begin
            tx_j_d    = sr_q[0] ? tx_j_q : ~tx_j_q;
            ones_d    = sr_q[0] ? ones_q + OW'(1) : '0;
            sr_d      = sr_q >> 1;
            bit_cnt_d = bit_cnt_q + 6'd1;
            state_d   = bit_state(bit_cnt_q);
          end else begin
            tx_se0_d  = 1'b1;
            eop_cnt_d = 2'd0;
            state_d   = StEop;
          end
        end
      end
      StEop: begin
        if (bit_end) begin
          if (eop_cnt_q == 2'd2) begin
            tx_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_j_d  = 1'b1;
            timer_d = '0;
            state_d = StIdle;
          end else if (eop_cnt_q == 2'd1) begin
            tx_se0_d  = 1'b0;
            tx_j_d    = 1'b1;
            eop_cnt_d = 2'd2;
          end else begin
            eop_cnt_d = 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset idles the line at J immediately.
  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      nbits_q   <= '0;
      ones_q    <= '0;
      eop_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_j_q    <= 1'b1;
      tx_se0_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      nbits_q   <= nbits_d;
      ones_q    <= ones_d;
      eop_cnt_q <= eop_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tx_en_q   <= tx_en_d;
      tx_j_q    <= tx_j_d;
      tx_se0_q  <= tx_se0_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.tx_en  = tx_en_q;
  assign bus.tx_j   = tx_j_q;
  assign bus.tx_se0 = tx_se0_q;

endmodule

// File: tb/tb_usb_fs_packet_tx.sv
// Directed bench for usb_fs_packet_tx: captures the line per clock, decodes
// NRZI/stuffing/EOP with a receiver model and compares against hand values.
module tb_usb_fs_packet_tx;
  logic clk_48 = 1'b0;
  logic rst;

  usb_fs_packet_tx_if bus ();

  usb_fs_packet_tx dut (
    .clk_48 (clk_48),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #5 clk_48 = ~clk_48;

  int errors = 0;
  int checks = 0;

  // Per-cycle line capture.
  logic cyc_j   [0:1023];
  logic cyc_se0 [0:1023];
  int   ncyc;
  logic end_done, end_busy;
  int   busy_bad, side_bad;

  // Receiver model results.
  int          lv [0:255];
  logic        dbits [0:255];
  int          nb, ndata, nstuff, stuff_err, hold_err, max_run;
  logic        eop_ok;
  logic [31:0] pkt;

  task automatic pulse_start(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
    bus.start = 1'b1;
    bus.pid   = p;
    bus.addr  = a;
    bus.endp  = e;
    @(negedge clk_48);
    bus.start = 1'b0;
  endtask

  // Records line samples while tx_en is high; optionally pulses start mid-packet.
  task automatic capture(input int inject_at);
    ncyc     = 0;
    busy_bad = 0;
    side_bad = 0;
    checks++;
    if (bus.tx_en !== 1'b1) begin
      errors++;
      $display("FAIL tx_en_first_cycle: got %b want 1", bus.tx_en);
    end
    while (bus.tx_en === 1'b1 && ncyc < 1000) begin
      cyc_j[ncyc]   = bus.tx_j;
      cyc_se0[ncyc] = bus.tx_se0;
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.err !== 1'b0 || bus.done !== 1'b0) side_bad++;
      if (ncyc == inject_at) begin
        bus.start = 1'b1;
        bus.pid   = 4'h2;
        bus.addr  = 7'h55;
        bus.endp  = 4'h3;
      end else if (ncyc == inject_at + 1) begin
        bus.start = 1'b0;
      end
      ncyc++;
      @(negedge clk_48);
    end
    bus.start = 1'b0;
    end_done  = bus.done;
    end_busy  = bus.busy;
  endtask

  function automatic logic [7:0] get_byte(input int k);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = dbits[8 * k + i];
    return v;
  endfunction

  // NRZI decode from idle J, unstuff after six 1s, split off SE0 SE0 J.
  task automatic decode();
    int prev, run, lastlv, ones, d;
    hold_err = (ncyc % 4 != 0) ? 1 : 0;
    nb = ncyc / 4;
    if (nb > 256) nb = 256;
    for (int b = 0; b < nb; b++) begin
      for (int k = 1; k < 4; k++)
        if (cyc_j[4*b+k] !== cyc_j[4*b] || cyc_se0[4*b+k] !== cyc_se0[4*b]) hold_err++;
      lv[b] = cyc_se0[4*b] ? 2 : (cyc_j[4*b] ? 1 : 0);
    end
    for (int i = 0; i < 256; i++) dbits[i] = 1'b0;
    eop_ok = (nb >= 3) && lv[nb-3] == 2 && lv[nb-2] == 2 && lv[nb-1] == 1;
    prev = 1; run = 0; lastlv = -1; max_run = 0;
    ones = 0; ndata = 0; nstuff = 0; stuff_err = 0;
    for (int b = 0; b < nb - 3; b++) begin
      if (lv[b] == 2) eop_ok = 1'b0;
      d    = (lv[b] == prev) ? 1 : 0;
      prev = lv[b];
      run  = (lv[b] == lastlv) ? run + 1 : 1;
      lastlv = lv[b];
      if (run > max_run) max_run = run;
      if (ones == 6) begin
        nstuff++;
        if (d != 0) stuff_err++;
        ones = 0;
      end else begin
        if (ndata < 256) dbits[ndata] = d[0];
        ndata++;
        ones = (d != 0) ? ones + 1 : 0;
      end
    end
    pkt = {get_byte(0), get_byte(1), get_byte(2), get_byte(3)};
  endtask

  // Reflected-form CRC5: register shifts right, sent LSB first.
  function automatic logic [4:0] crc5_ref(input logic [10:0] field);
    logic [4:0] r;
    logic       fb;
    r = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = r[0] ^ field[i];
      r  = r >> 1;
      if (fb) r = r ^ 5'b10100;
    end
    return ~r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_48);
    checks++;
    if (bus.tx_en !== 1'b0 || bus.tx_j !== 1'b1 || bus.tx_se0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_line: got en/j/se0=%b%b%b want 010", bus.tx_en, bus.tx_j, bus.tx_se0);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got busy/done/err=%b%b%b want 000", bus.busy, bus.done,
               bus.err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk_48);
    checks++;
    if (bus.tx_en !== 1'b0 || bus.busy !== 1'b0 || bus.tx_j !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: got en/busy/j=%b%b%b want 001", bus.tx_en, bus.busy,
               bus.tx_j);
    end
  endtask

  task automatic test_setup();
    pulse_start(4'hD, 7'h00, 4'h0);
    capture(-1);
    decode();
    checks++;
    if (ncyc !== 140) begin errors++; $display("FAIL setup_len: got %0d want 140", ncyc); end
    checks++;
    if (hold_err !== 0 || eop_ok !== 1'b1 || busy_bad !== 0 || side_bad !== 0) begin
      errors++;
      $display("FAIL setup_framing: hold=%0d eop=%b busy_bad=%0d side=%0d want 0 1 0 0",
               hold_err, eop_ok, busy_bad, side_bad);
    end
    checks++;
    if (ndata !== 32 || nstuff !== 0 || pkt !== 32'h802D0010) begin
      errors++;
      $display("FAIL setup_bytes: got %0d bits %0d stuff %h want 32 0 802d0010", ndata,
               nstuff, pkt);
    end
    checks++;
    if (end_done !== 1'b1 || end_busy !== 1'b0) begin
      errors++;
      $display("FAIL setup_done: got done/busy=%b%b want 10", end_done, end_busy);
    end
    @(negedge clk_48);
    checks++;
    if (bus.done !== 1'b0 || bus.tx_en !== 1'b0 || bus.tx_j !== 1'b1) begin
      errors++;
      $display("FAIL setup_done_width: got done/en/j=%b%b%b want 001", bus.done, bus.tx_en,
               bus.tx_j);
    end
  endtask

  task automatic test_in();
    pulse_start(4'h9, 7'h01, 4'h0);
    capture(-1);
    decode();
    checks++;
    if (ncyc !== 140 || hold_err !== 0 || eop_ok !== 1'b1) begin
      errors++;
      $display("FAIL in_len: got %0d hold=%0d eop=%b want 140 0 1", ncyc, hold_err, eop_ok);
    end
    checks++;
    if (ndata !== 32 || nstuff !== 0 || pkt !== 32'h806901E8) begin
      errors++;
      $display("FAIL in_bytes: got %0d bits %0d stuff %h want 32 0 806901e8", ndata, nstuff,
               pkt);
    end
    @(negedge clk_48);
  endtask

  task automatic test_out_stuffing();
    logic [6:0] a;
    logic [3:0] e;
    logic [4:0] c;
    pulse_start(4'h1, 7'h7F, 4'hF);
    capture(-1);
    decode();
    for (int i = 0; i < 7; i++) a[i] = dbits[16 + i];
    for (int i = 0; i < 4; i++) e[i] = dbits[23 + i];
    for (int i = 0; i < 5; i++) c[i] = dbits[27 + i];
    checks++;
    if (ndata !== 32 || pkt[31:16] !== 16'h80E1 || a !== 7'h7F || e !== 4'hF) begin
      errors++;
      $display("FAIL out_fields: got bits=%0d hdr=%h addr=%h endp=%h want 32 80e1 7f f",
               ndata, pkt[31:16], a, e);
    end
    checks++;
    if (c !== crc5_ref({4'hF, 7'h7F})) begin
      errors++;
      $display("FAIL out_crc: got %b want %b", c, crc5_ref({4'hF, 7'h7F}));
    end
    checks++;
    if (nstuff < 1 || stuff_err !== 0 || max_run > 7) begin
      errors++;
      $display("FAIL out_stuff: got stuffed=%0d bad=%0d max_run=%0d want >=1 0 <=7", nstuff,
               stuff_err, max_run);
    end
    checks++;
    if (ncyc !== 4 * (35 + nstuff) || hold_err !== 0 || eop_ok !== 1'b1) begin
      errors++;
      $display("FAIL out_len: got %0d hold=%0d eop=%b want %0d 0 1", ncyc, hold_err, eop_ok,
               4 * (35 + nstuff));
    end
    @(negedge clk_48);
  endtask

  task automatic test_back_to_back();
    pulse_start(4'h2, 7'h00, 4'h0);
    capture(-1);
    decode();
    checks++;
    if (ncyc !== 76 || ndata !== 16 || pkt !== 32'h80D20000 || eop_ok !== 1'b1) begin
      errors++;
      $display("FAIL ack_pkt: got len=%0d bits=%0d %h eop=%b want 76 16 80d20000 1", ncyc,
               ndata, pkt, eop_ok);
    end
    checks++;
    if (end_done !== 1'b1) begin
      errors++;
      $display("FAIL ack_done: got %b want 1", end_done);
    end
    // Start NAK in the done cycle itself.
    pulse_start(4'hA, 7'h00, 4'h0);
    capture(-1);
    decode();
    checks++;
    if (ncyc !== 76 || ndata !== 16 || pkt !== 32'h805A0000 || hold_err !== 0) begin
      errors++;
      $display("FAIL nak_pkt: got len=%0d bits=%0d %h hold=%0d want 76 16 805a0000 0", ncyc,
               ndata, pkt, hold_err);
    end
    @(negedge clk_48);
  endtask

  task automatic test_data_pid();
    pulse_start(4'h3, 7'h00, 4'h0);
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.tx_en !== 1'b0) begin
      errors++;
      $display("FAIL data_err: got err/busy/en=%b%b%b want 100", bus.err, bus.busy, bus.tx_en);
    end
    @(negedge clk_48);
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.tx_en !== 1'b0) begin
      errors++;
      $display("FAIL data_err_width: got err/busy/en=%b%b%b want 000", bus.err, bus.busy,
               bus.tx_en);
    end
  endtask

  task automatic test_start_while_busy();
    pulse_start(4'hD, 7'h00, 4'h0);
    capture(40);
    decode();
    checks++;
    if (ncyc !== 140 || ndata !== 32 || pkt !== 32'h802D0010 || hold_err !== 0) begin
      errors++;
      $display("FAIL busy_start_pkt: got len=%0d bits=%0d %h hold=%0d want 140 32 802d0010 0",
               ncyc, ndata, pkt, hold_err);
    end
    checks++;
    if (side_bad !== 0 || busy_bad !== 0) begin
      errors++;
      $display("FAIL busy_start_side: got side=%0d busy_bad=%0d want 0 0", side_bad, busy_bad);
    end
    @(negedge clk_48);
    checks++;
    if (bus.tx_en !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_after: got en/busy=%b%b want 00", bus.tx_en, bus.busy);
    end
  endtask

  task automatic test_reset_mid_crc();
    int bad;
    pulse_start(4'hD, 7'h00, 4'h0);
    repeat (110) @(negedge clk_48);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.tx_en !== 1'b0 || bus.tx_j !== 1'b1 || bus.busy !== 1'b0 || bus.tx_se0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got en/j/busy/se0=%b%b%b%b want 0100", bus.tx_en, bus.tx_j,
               bus.busy, bus.tx_se0);
    end
    repeat (2) @(negedge clk_48);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_48);
      if (bus.done !== 1'b0 || bus.tx_en !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: got %0d active cycles want 0", bad);
    end
    pulse_start(4'hD, 7'h00, 4'h0);
    capture(-1);
    decode();
    checks++;
    if (ncyc !== 140 || pkt !== 32'h802D0010 || eop_ok !== 1'b1 || end_done !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_resend: got len=%0d %h eop=%b done=%b want 140 802d0010 1 1",
               ncyc, pkt, eop_ok, end_done);
    end
    @(negedge clk_48);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pid   = 4'h0;
    bus.addr  = 7'h00;
    bus.endp  = 4'h0;
    rst       = 1'b1;
    test_reset();
    test_setup();
    test_in();
    test_out_stuffing();
    test_back_to_back();
    test_data_pid();
    test_start_while_busy();
    test_reset_mid_crc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
